// File: rtl/instr_fetch_unit.sv
// Program counter owner and single-outstanding instruction fetcher feeding control_unit.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter int              XLEN           = 32,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    input  logic            pc_write,
    input  logic [1:0]      pc_select,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] alu_result,
    output logic            misalign_err,
    output logic            fetch_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        VALID,
        HOLD,
        FAULT
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] next_pc;
    logic            tmo_hit;

    always_comb begin
        next_pc = pc_q + XLEN'(4);
        case (pc_select)
            2'b01:   next_pc = branch_target;
            2'b10:   next_pc = jump_target;
            2'b11:   next_pc = alu_result & ~XLEN'(1);
            default: next_pc = pc_q + XLEN'(4);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = VALID;
                end else if (tmo_hit) begin
                    state_d = REQ;
                end
            end
            VALID: begin
                if (instr_ready) state_d = HOLD;
            end
            HOLD: begin
                if (pc_write) begin
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = FAULT;
                    end
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          fetch_err_q, fetch_err_d;

    // The counter only advances on WAIT cycles that lack rvalid; hitting the limit re-issues the fetch.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        fetch_err_d = fetch_err_q;
        tmo_hit     = 1'b0;
        if (state_q == REQ && imem_gnt) begin
            tmo_cnt_d = '0;
        end else if (state_q == WAIT && !imem_rvalid) begin
            if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit     = 1'b1;
                fetch_err_d = 1'b1;
                tmo_cnt_d   = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q   <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
    assign fetch_err  = 1'b0;
`endif

    assign imem_req     = (state_q == REQ);
    assign imem_addr    = pc_q;
    assign instr        = instr_q;
    assign instr_valid  = (state_q == VALID);
    assign pc           = pc_q;
    assign pc_plus4     = pc_q + XLEN'(4);
    assign misalign_err = misalign_q;

endmodule
